simd_operand_fifo: RTL and testbench

//  Parametrised, handshaked staging buffer for SIMD bilinear-interpolation operand bundles.

---
 rtl/simd_operand_fifo.sv | 120 ++++++++++++
 tb/tb_simd_operand_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/simd_operand_fifo.sv
// First-word-fall-through staging FIFO for SIMD bilinear-interpolation operand bundles.
// Head outputs are zeroed when empty and per lane when that lane's enable is clear.
module simd_operand_fifo #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0][PIX_W-1:0]      I00_in,
  input  logic [LANES-1:0][PIX_W-1:0]      I10_in,
  input  logic [LANES-1:0][PIX_W-1:0]      I01_in,
  input  logic [LANES-1:0][PIX_W-1:0]      I11_in,
  input  logic [LANES-1:0][FRAC_W-1:0]     alpha_in,
  input  logic [LANES-1:0][FRAC_W-1:0]     beta_in,
  input  logic [LANES-1:0]                 lane_en_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][PIX_W-1:0]      I00_out,
  output logic [LANES-1:0][PIX_W-1:0]      I10_out,
  output logic [LANES-1:0][PIX_W-1:0]      I01_out,
  output logic [LANES-1:0][PIX_W-1:0]      I11_out,
  output logic [LANES-1:0][FRAC_W-1:0]     alpha_out,
  output logic [LANES-1:0][FRAC_W-1:0]     beta_out,
  output logic [LANES-1:0]                 lane_en_out,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [LANES-1:0][PIX_W-1:0]  i00_mem   [DEPTH];
  logic [LANES-1:0][PIX_W-1:0]  i10_mem   [DEPTH];
  logic [LANES-1:0][PIX_W-1:0]  i01_mem   [DEPTH];
  logic [LANES-1:0][PIX_W-1:0]  i11_mem   [DEPTH];
  logic [LANES-1:0][FRAC_W-1:0] alpha_mem [DEPTH];
  logic [LANES-1:0][FRAC_W-1:0] beta_mem  [DEPTH];
  logic [LANES-1:0]             en_mem    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // in_ready depends only on state (and reset), never on out_ready.
  assign in_ready  = rst_n & (count_q < CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; output masking hides stale contents.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      i00_mem[wr_ptr_q]   <= I00_in;
      i10_mem[wr_ptr_q]   <= I10_in;
      i01_mem[wr_ptr_q]   <= I01_in;
      i11_mem[wr_ptr_q]   <= I11_in;
      alpha_mem[wr_ptr_q] <= alpha_in;
      beta_mem[wr_ptr_q]  <= beta_in;
      en_mem[wr_ptr_q]    <= lane_en_in;
    end
  end

  always_comb begin
    I00_out     = '0;
    I10_out     = '0;
    I01_out     = '0;
    I11_out     = '0;
    alpha_out   = '0;
    beta_out    = '0;
    lane_en_out = out_valid ? en_mem[rd_ptr_q] : '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en_out[k]) begin
        I00_out[k]   = i00_mem[rd_ptr_q][k];
        I10_out[k]   = i10_mem[rd_ptr_q][k];
        I01_out[k]   = i01_mem[rd_ptr_q][k];
        I11_out[k]   = i11_mem[rd_ptr_q][k];
        alpha_out[k] = alpha_mem[rd_ptr_q][k];
        beta_out[k]  = beta_mem[rd_ptr_q][k];
      end
    end
  end

endmodule

// File: tb/tb_simd_operand_fifo.sv
// Directed bench for simd_operand_fifo with a queue-based scoreboard of expected head bundles.
module tb_simd_operand_fifo;

  typedef struct packed {
    logic [31:0] i00;
    logic [31:0] i10;
    logic [31:0] i01;
    logic [31:0] i11;
    logic [31:0] al;
    logic [31:0] be;
    logic [3:0]  en;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0][7:0] I00_in, I10_in, I01_in, I11_in, alpha_in, beta_in;
  logic [3:0][7:0] I00_out, I10_out, I01_out, I11_out, alpha_out, beta_out;
  logic [3:0] lane_en_in, lane_en_out;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;
  bundle_t sb[$];

  always #5 clk = ~clk;

  simd_operand_fifo #(.LANES(4), .PIX_W(8), .FRAC_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .I00_in(I00_in), .I10_in(I10_in), .I01_in(I01_in), .I11_in(I11_in),
    .alpha_in(alpha_in), .beta_in(beta_in), .lane_en_in(lane_en_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .I00_out(I00_out), .I10_out(I10_out), .I01_out(I01_out), .I11_out(I11_out),
    .alpha_out(alpha_out), .beta_out(beta_out), .lane_en_out(lane_en_out),
    .count(count)
  );

  function automatic bundle_t mk(input logic [7:0] tag, input logic [3:0] en);
    bundle_t b;
    for (int k = 0; k < 4; k++) begin
      b.i00[k*8 +: 8] = tag + 8'(k);
      b.i10[k*8 +: 8] = tag + 8'(16 + k);
      b.i01[k*8 +: 8] = tag + 8'(32 + k);
      b.i11[k*8 +: 8] = tag + 8'(48 + k);
      b.al[k*8 +: 8]  = ~tag + 8'(k);
      b.be[k*8 +: 8]  = tag ^ 8'(8'h5A + k);
    end
    b.en = en;
    return b;
  endfunction

  function automatic bundle_t masked(input bundle_t b);
    bundle_t m = b;
    for (int k = 0; k < 4; k++) begin
      if (!b.en[k]) begin
        m.i00[k*8 +: 8] = 8'h00;
        m.i10[k*8 +: 8] = 8'h00;
        m.i01[k*8 +: 8] = 8'h00;
        m.i11[k*8 +: 8] = 8'h00;
        m.al[k*8 +: 8]  = 8'h00;
        m.be[k*8 +: 8]  = 8'h00;
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bundle_t b, input logic v);
    in_valid   = v;
    I00_in     = b.i00;
    I10_in     = b.i10;
    I01_in     = b.i01;
    I11_in     = b.i11;
    alpha_in   = b.al;
    beta_in    = b.be;
    lane_en_in = b.en;
  endtask

  task automatic check_outputs(input string tag);
    bundle_t e;
    int n = sb.size();
    e = (n != 0) ? masked(sb[0]) : '0;
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(n < 4));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    chk({tag, ".i00"}, 64'(I00_out), 64'(e.i00));
    chk({tag, ".i10"}, 64'(I10_out), 64'(e.i10));
    chk({tag, ".i01"}, 64'(I01_out), 64'(e.i01));
    chk({tag, ".i11"}, 64'(I11_out), 64'(e.i11));
    chk({tag, ".alpha"}, 64'(alpha_out), 64'(e.al));
    chk({tag, ".beta"}, 64'(beta_out), 64'(e.be));
    chk({tag, ".lane_en"}, 64'(lane_en_out), 64'(e.en));
  endtask

  // Inputs are already set; sample at negedge, then advance model across the next posedge.
  task automatic cycle(input string tag);
    bundle_t b;
    logic do_push, do_pop;
    @(negedge clk);
    check_outputs(tag);
    b = '{i00: I00_in, i10: I10_in, i01: I01_in, i11: I11_in,
          al: alpha_in, be: beta_in, en: lane_en_in};
    do_push = in_valid && (sb.size() < 4);
    do_pop  = out_ready && (sb.size() != 0);
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(b);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive('0, 1'b0);
    #2;
    chk("rst.in_ready_low", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("reset_release");

    // Fill to full, then a refused fifth push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(mk(8'(8'h10 + i), 4'hF), 1'b1);
      cycle("fill");
    end
    chk("full.i00_lane0", 64'(I00_out[0]), 64'h10);
    drive(mk(8'h14, 4'hF), 1'b1);
    cycle("push_when_full");
    drive('0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain.i00_lane0", 64'(I00_out[0]), 64'(8'h10 + i));
      cycle("drain");
    end
    cycle("drained");

    // Concurrent push/pop at occupancy 2 across pointer wrap.
    out_ready = 1'b0;
    drive(mk(8'h1E, 4'hF), 1'b1);
    cycle("pre1");
    drive(mk(8'h1F, 4'hF), 1'b1);
    cycle("pre2");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(mk(8'(8'h20 + i), 4'hF), 1'b1);
      cycle("concurrent");
      chk("concurrent.count", 64'(count), 64'd2);
    end
    drive('0, 1'b0);
    cycle("tail1");
    cycle("tail2");
    cycle("tail_empty");

    // Lane mask with all fields 0xFF.
    out_ready = 1'b0;
    drive('{i00: '1, i10: '1, i01: '1, i11: '1, al: '1, be: '1, en: 4'b0101}, 1'b1);
    cycle("mask_push");
    drive('0, 1'b0);
    cycle("mask_hold");
    chk("mask.i00", 64'(I00_out), 64'h00FF00FF);
    chk("mask.beta", 64'(beta_out), 64'h00FF00FF);
    chk("mask.lane_en", 64'(lane_en_out), 64'h5);
    out_ready = 1'b1;
    cycle("mask_pop");

    // Flush at occupancy 3 with a concurrent push of 0x55.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(8'(8'h30 + i), 4'hF), 1'b1);
      cycle("flush_fill");
    end
    flush = 1'b1;
    drive(mk(8'h55, 4'hF), 1'b1);
    cycle("flush_cycle");
    flush = 1'b0;
    drive('0, 1'b0);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    cycle("after_flush");
    drive(mk(8'h40, 4'hF), 1'b1);
    cycle("post_flush_push");
    drive('0, 1'b0);
    chk("post_flush.i00_lane0", 64'(I00_out[0]), 64'h40);
    out_ready = 1'b1;
    cycle("post_flush_pop");

    // Asynchronous reset mid-operation at occupancy 2.
    out_ready = 1'b0;
    drive(mk(8'h60, 4'hF), 1'b1);
    cycle("mr_fill");
    drive(mk(8'h61, 4'hF), 1'b1);
    cycle("mr_fill");
    drive('0, 1'b0);
    chk("mr.pre_count", 64'(count), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr.out_valid", 64'(out_valid), 64'd0);
    chk("mr.count", 64'(count), 64'd0);
    chk("mr.in_ready", 64'(in_ready), 64'd0);
    chk("mr.i00", 64'(I00_out), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("mr_released");
    drive(mk(8'h70, 4'b0011), 1'b1);
    cycle("mr_push");
    drive('0, 1'b0);
    out_ready = 1'b1;
    cycle("mr_pop");
    cycle("mr_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
